// File: rtl/data_memory_controller.sv
// -----------------------------------------------------------------------------
// data_memory_controller
//
// Connects the RV32E load/store unit to four byte-wide single-port memory
// banks. Lane i holds the byte addresses with addr[1:0] == i. The controller
// accepts one request at a time. It splits the request into per-lane row
// addresses, write enables and write bytes. For loads, it reassembles the
// returned bytes and applies sign or zero extension.
//
// A misaligned access still takes only one bank cycle. Each lane gets its own
// row, so a lane that lies before the start lane reads or writes the next row.
//
// Ports:
//   clk, rst_n                clock (rising edge), async active-low reset
//   req_valid / req_ready     request handshake (ready only in IDLE)
//   req_we, req_funct3        store flag and RV funct3 access size/sign
//   req_addr, req_wdata       byte address and LSB-aligned store data
//   rsp_valid / rsp_ready     response handshake
//   rsp_rdata, rsp_err        extended load data (0 for stores/errors), reject
//   bank_we, bank_addr,       per-lane write enable, row address, write byte
//   bank_wdata
//   bank_rdata                per-lane read byte, valid one clock after a read
// -----------------------------------------------------------------------------
module data_memory_controller #(
    parameter int DATA_DEPTH = 4096,
    localparam int RW = $clog2(DATA_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [3:0]           bank_we,
    output logic [3:0][RW-1:0]   bank_addr,
    output logic [3:0][7:0]      bank_wdata,
    input  logic [3:0][7:0]      bank_rdata
);

    localparam logic [32:0] MEM_BYTES = 33'(4 * DATA_DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t          state;
    logic [RW+1:0]   lat_addr;
    logic            lat_we;
    logic [2:0]      lat_funct3;
    logic [31:0]     lat_wdata;

    logic [2:0]      req_size;
    logic [32:0]     req_end;
    logic            funct_bad;
    logic            req_error;
    logic [2:0]      lat_size;
    logic [3:0][1:0] lane_off;
    logic [3:0]      lane_touch;
    logic [RW-1:0]   base_row;
    logic [3:0][7:0] ld_byte;
    logic [31:0]     ld_data;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Validate the incoming request before it is accepted. The end address is
    // computed with 33 bits so that an access near 0xFFFFFFFF cannot wrap
    // around and pass the bounds check.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            2'b10:   req_size = 3'd4;
            default: req_size = 3'd1;
        endcase
        if (req_we)
            funct_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            funct_bad = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        req_end   = {1'b0, req_addr} + {30'd0, req_size} - 33'd1;
        req_error = funct_bad || (req_end >= MEM_BYTES);
    end

    // Lane decode from the latched request. Lane l holds byte offset
    // (l - addr[1:0]) mod 4. A lane below the start lane wraps into the next
    // row. Untouched lanes stay on the base row, with no write and a zero byte.
    always_comb begin
        case (lat_funct3[1:0])
            2'b00:   lat_size = 3'd1;
            2'b01:   lat_size = 3'd2;
            default: lat_size = 3'd4;
        endcase
        base_row = lat_addr[RW+1:2];
        for (int l = 0; l < 4; l++) begin
            lane_off[l]   = 2'(l) - lat_addr[1:0];
            lane_touch[l] = ({1'b0, lane_off[l]} < lat_size);
            bank_we[l]    = (state == ACCESS) && lat_we && lane_touch[l];
            bank_addr[l]  = base_row;
            bank_wdata[l] = 8'd0;
            if (lane_touch[l]) begin
                bank_addr[l] = base_row + RW'(2'(l) < lat_addr[1:0]);
                if (lat_we)
                    bank_wdata[l] = lat_wdata[{lane_off[l], 3'b000} +: 8];
            end
        end
    end

    // Rotate the returned bank bytes back into access order, then extend them
    // according to the load type.
    always_comb begin
        for (int k = 0; k < 4; k++)
            ld_byte[k] = bank_rdata[lat_addr[1:0] + 2'(k)];
        case (lat_funct3)
            3'b000:  ld_data = {{24{ld_byte[0][7]}}, ld_byte[0]};
            3'b001:  ld_data = {{16{ld_byte[1][7]}}, ld_byte[1], ld_byte[0]};
            3'b100:  ld_data = {24'd0, ld_byte[0]};
            3'b101:  ld_data = {16'd0, ld_byte[1], ld_byte[0]};
            default: ld_data = {ld_byte[3], ld_byte[2], ld_byte[1], ld_byte[0]};
        endcase
    end

    // Request FSM. Only the low address bits that select a lane and a row are
    // latched; the full address is only needed for the bounds check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_wdata  <= 32'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr   <= req_addr[RW+1:0];
                        lat_we     <= req_we;
                        lat_funct3 <= req_funct3;
                        lat_wdata  <= req_wdata;
                        rsp_rdata  <= 32'd0;
                        rsp_err    <= req_error;
                        state      <= req_error ? RESP : ACCESS;
                    end
                end
                ACCESS:  state <= lat_we ? RESP : CAPTURE;
                CAPTURE: begin
                    rsp_rdata <= ld_data;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// -----------------------------------------------------------------------------
// tb_data_memory_controller
//
// Directed, table-driven bench for data_memory_controller. Four byte banks are
// modelled as synchronous single-port RAMs. Each table entry is one request
// with hand-computed expected error, load data, bank write lanes and latency.
// Hand-written sequences cover row splitting, backpressure and reset during a
// store.
// -----------------------------------------------------------------------------
module tb_data_memory_controller;

    localparam int DATA_DEPTH = 4096;
    localparam int RW = $clog2(DATA_DEPTH);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [2:0]          req_funct3;
    logic [31:0]         req_addr;
    logic [31:0]         req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic [3:0]          bank_we;
    logic [3:0][RW-1:0]  bank_addr;
    logic [3:0][7:0]     bank_wdata;
    logic [3:0][7:0]     bank_rdata;

    logic [7:0] mem [4][DATA_DEPTH];
    logic       mem_clear;

    int errors = 0;
    int checks = 0;

    int                 got_lat;
    logic [3:0]         we_seen;
    logic [3:0][RW-1:0] acc_baddr;
    logic [3:0][7:0]    acc_wdata;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_we;
        int          exp_lat;
    } vec_t;

    vec_t vecs[26];

    data_memory_controller #(.DATA_DEPTH(DATA_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata)
    );

    always #5 clk = ~clk;

    // Bank model: each lane writes on a write cycle, and otherwise returns
    // the addressed byte on the next clock.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int l = 0; l < 4; l++)
                for (int r = 0; r < DATA_DEPTH; r++)
                    mem[l][r] <= 8'h00;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (bank_we[l])
                    mem[l][bank_addr[l]] <= bank_wdata[l];
                else
                    bank_rdata[l] <= mem[l][bank_addr[l]];
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic exp_err, input logic [31:0] exp_rdata,
                                input logic [3:0] exp_we, input int exp_lat);
        vec_t v;
        v.we = we;             v.f3 = f3;
        v.addr = addr;         v.wdata = wdata;
        v.exp_err = exp_err;   v.exp_rdata = exp_rdata;
        v.exp_we = exp_we;     v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Issues one request from a negedge, then follows it to the response.
    // The response is held for 'hold' cycles before the handshake, and the
    // response outputs are checked on every held cycle.
    task automatic applyStimulus(input string name, input vec_t v, input int hold,
                                 input logic [RW-1:0] hold_row);
        @(negedge clk);
        checkOutput({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        got_lat   = 0;
        we_seen   = 4'b0000;
        acc_baddr = '0;
        acc_wdata = '0;
        while (!rsp_valid && got_lat < 20) begin
            we_seen = we_seen | bank_we;
            if (got_lat == 0) begin
                acc_baddr = bank_addr;
                acc_wdata = bank_wdata;
            end
            @(posedge clk);
            @(negedge clk);
            got_lat++;
        end
        checkOutput({name, "_lat"}, 32'(got_lat), 32'(v.exp_lat));
        checkOutput({name, "_err"}, 32'(rsp_err), 32'(v.exp_err));
        checkOutput({name, "_rdata"}, rsp_rdata, v.exp_rdata);
        checkOutput({name, "_we"}, 32'(we_seen), 32'(v.exp_we));
        for (int i = 0; i < hold; i++) begin
            checkOutput({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({name, "_hold_ready"}, 32'(req_ready), 32'd0);
            checkOutput({name, "_hold_rdata"}, rsp_rdata, v.exp_rdata);
            for (int l = 0; l < 4; l++)
                checkOutput({name, "_hold_row"}, 32'(bank_addr[l]), 32'(hold_row));
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({name, "_done_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({name, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = mk(1, 3'b010, 32'h100,      32'hDEADBEEF, 0, 32'h0,        4'b1111, 1);
        vecs[1]  = mk(0, 3'b010, 32'h100,      32'h0,        0, 32'hDEADBEEF, 4'b0000, 2);
        vecs[2]  = mk(1, 3'b000, 32'h103,      32'h12345680, 0, 32'h0,        4'b1000, 1);
        vecs[3]  = mk(0, 3'b000, 32'h103,      32'h0,        0, 32'hFFFFFF80, 4'b0000, 2);
        vecs[4]  = mk(0, 3'b100, 32'h103,      32'h0,        0, 32'h00000080, 4'b0000, 2);
        vecs[5]  = mk(0, 3'b010, 32'h100,      32'h0,        0, 32'h80ADBEEF, 4'b0000, 2);
        vecs[6]  = mk(1, 3'b010, 32'h0FE,      32'h11223344, 0, 32'h0,        4'b1111, 1);
        vecs[7]  = mk(0, 3'b010, 32'h0FE,      32'h0,        0, 32'h11223344, 4'b0000, 2);
        vecs[8]  = mk(0, 3'b001, 32'h0FF,      32'h0,        0, 32'h00002233, 4'b0000, 2);
        vecs[9]  = mk(0, 3'b010, 32'h100,      32'h0,        0, 32'h80AD1122, 4'b0000, 2);
        vecs[10] = mk(1, 3'b010, 32'h3FFC,     32'hCAFEF00D, 0, 32'h0,        4'b1111, 1);
        vecs[11] = mk(0, 3'b010, 32'h3FFC,     32'h0,        0, 32'hCAFEF00D, 4'b0000, 2);
        vecs[12] = mk(0, 3'b001, 32'h3FFE,     32'h0,        0, 32'hFFFFCAFE, 4'b0000, 2);
        vecs[13] = mk(0, 3'b101, 32'h3FFE,     32'h0,        0, 32'h0000CAFE, 4'b0000, 2);
        vecs[14] = mk(0, 3'b010, 32'h3FFD,     32'h0,        1, 32'h0,        4'b0000, 0);
        vecs[15] = mk(0, 3'b011, 32'h200,      32'h0,        1, 32'h0,        4'b0000, 0);
        vecs[16] = mk(1, 3'b100, 32'h200,      32'h000000AA, 1, 32'h0,        4'b0000, 0);
        vecs[17] = mk(1, 3'b001, 32'h3FFF,     32'h0000BBBB, 1, 32'h0,        4'b0000, 0);
        vecs[18] = mk(0, 3'b000, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        4'b0000, 0);
        vecs[19] = mk(1, 3'b001, 32'h201,      32'hABCD5566, 0, 32'h0,        4'b0110, 1);
        vecs[20] = mk(0, 3'b101, 32'h201,      32'h0,        0, 32'h00005566, 4'b0000, 2);
        vecs[21] = mk(0, 3'b010, 32'h200,      32'h0,        0, 32'h00556600, 4'b0000, 2);
        vecs[22] = mk(0, 3'b001, 32'h101,      32'h0,        0, 32'hFFFFAD11, 4'b0000, 2);
        vecs[23] = mk(0, 3'b110, 32'h100,      32'h0,        1, 32'h0,        4'b0000, 0);
        vecs[24] = mk(0, 3'b000, 32'h3FFF,     32'h0,        0, 32'hFFFFFFCA, 4'b0000, 2);
        vecs[25] = mk(1, 3'b011, 32'h100,      32'h0,        1, 32'h0,        4'b0000, 0);

        rst_n      = 1'b0;
        mem_clear  = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_we", 32'(bank_we), 32'd0);
        checkOutput("rst_wdata", bank_wdata, 32'd0);
        for (int l = 0; l < 4; l++)
            checkOutput("rst_row", 32'(bank_addr[l]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++)
            applyStimulus($sformatf("v%0d", i), vecs[i], 0, '0);

        // Backpressure: hold the LW 0x100 response for five cycles.
        applyStimulus("bp", mk(0, 3'b010, 32'h100, 32'h0, 0, 32'h80AD1122, 4'b0000, 2),
                      5, 12'h040);

        // Misaligned store: lanes 2,3 use row 0x3F and lanes 0,1 use row 0x40.
        applyStimulus("mis", mk(1, 3'b010, 32'h0FE, 32'h01020304, 0, 32'h0, 4'b1111, 1),
                      0, '0);
        checkOutput("mis_row0", 32'(acc_baddr[0]), 32'h040);
        checkOutput("mis_row1", 32'(acc_baddr[1]), 32'h040);
        checkOutput("mis_row2", 32'(acc_baddr[2]), 32'h03F);
        checkOutput("mis_row3", 32'(acc_baddr[3]), 32'h03F);
        checkOutput("mis_wdata", acc_wdata, 32'h03040102);

        // Aligned store: every lane uses row 0x40.
        applyStimulus("al", mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 1),
                      0, '0);
        for (int l = 0; l < 4; l++)
            checkOutput("al_row", 32'(acc_baddr[l]), 32'h040);
        checkOutput("al_wdata", acc_wdata, 32'hDEADBEEF);

        // Reset in the middle of a store's ACCESS cycle must not write.
        applyStimulus("rs_pre", mk(1, 3'b010, 32'h300, 32'h12345678, 0, 32'h0, 4'b1111, 1),
                      0, '0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h300;
        req_wdata  = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rs_access_we", 32'(bank_we), 32'hF);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rs_we_drop", 32'(bank_we), 32'd0);
        checkOutput("rs_ready", 32'(req_ready), 32'd1);
        checkOutput("rs_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rs_rel_ready", 32'(req_ready), 32'd1);
        checkOutput("rs_rel_valid", 32'(rsp_valid), 32'd0);
        applyStimulus("rs_post", mk(0, 3'b010, 32'h300, 32'h0, 0, 32'h12345678, 4'b0000, 2),
                      0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
- Sits between the RV32E load/store unit and four byte-wide single-port memory banks (lane i holds byte addresses with addr[1:0]==i).
- Accepts one 32-bit load/store request at a time and splits it into per-lane bank write enables, row addresses and write bytes.
- Reassembles returned bytes with sign/zero extension and returns one response per request.
- Misaligned accesses complete in a single bank cycle by giving each lane its own row address.

Parameters:
- DATA_DEPTH, 4096, rows per bank; total memory = 4*DATA_DEPTH bytes.
- RW, $clog2(DATA_DEPTH), row-address width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept; high only in IDLE.
- req_we  input  1  1=store, 0=load.
- req_funct3  input  3  RV funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- rsp_err  output  1  request rejected, no bank access.
- bank_we  output  4  per-lane write enable.
- bank_addr  output  4xRW  per-lane row address.
- bank_wdata  output  4x8  per-lane write byte.
- bank_rdata  input  4x8  per-lane read byte; valid one clock after a non-write cycle.

Behaviour:
- States: IDLE, ACCESS, CAPTURE, RESP.
- Reset (async, any state): state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0. Latched request regs, bank_addr and bank_wdata are 0. bank_we=0 immediately, because it is decoded from state.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge: latch addr, we, funct3, wdata.
  - Error check: size = 1/2/4 from funct3[1:0]. Error if funct3 is illegal (load 011/110/111, store funct3[2]=1 or 011) or addr+size-1 >= 4*DATA_DEPTH (no wrap-around). On error go to RESP with rsp_err=1 and rsp_rdata=0.
  - Otherwise go to ACCESS.
- Lane mapping, for byte k in 0..size-1 at A=addr+k: lane = A[1:0], row = A>>2.
- Untouched lanes: bank_addr = addr>>2, bank_we=0, bank_wdata=0.
- bank_addr and bank_wdata are decoded from the latched request and held constant in ACCESS, CAPTURE and RESP.
- ACCESS (1 cycle):
  - Store: bank_we set for touched lanes; lane of byte k gets req_wdata[8k+7:8k]. Go to RESP, rsp_err=0, rsp_rdata=0.
  - Load: bank_we=0. Go to CAPTURE.
- CAPTURE (1 cycle), load only:
  - Byte k = bank_rdata[(addr+k)%4].
  - Assemble, then extend: LB/LH sign-extend, LBU/LHU zero-extend.
  - Register the result into rsp_rdata. Go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable.
  - On rsp_ready, go to IDLE and drop rsp_valid.
- Latency, counted from the accept edge E0:
  - Load: rsp_valid high after E2.
  - Store: rsp_valid high after E1; bank write occurs at E1.
  - Error: rsp_valid high after E0.
- Back-to-back: a new request can be accepted no earlier than the cycle after the response handshake. req_ready and rsp_valid are never both high.
- Reset during ACCESS: bank_we drops combinationally, so no partial write occurs after reset assertion.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF; then LW 0x100. Store: bank_we=1111, all bank_addr=0x40. Load: rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
2. SB 0x103 data 0x80; LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080; only bank_we[3] pulsed.
3. Misaligned SW 0x0FE data 0x11223344: lanes 2,3 row 0x3F, lanes 0,1 row 0x40, one write cycle. LW 0x0FE -> 0x11223344. LH 0x0FF -> sign-extended 0x00002233.
4. Bounds, DATA_DEPTH=4096: LW 0x3FFC OK. LW 0x3FFD -> rsp_err=1, rsp_rdata=0, bank_we never set. Load funct3=011 -> rsp_err=1.
5. Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid, rsp_rdata and bank_addr stay stable; req_ready=0 throughout; a new request is accepted only after the handshake.
6. Assert rst_n=0 mid-ACCESS of a store: bank_we=0 in the same cycle, memory unchanged (verified by a later LW), state=IDLE, req_ready=1 after release.
